busca_instrucao: RTL and testbench
==================================

Name: busca_instrucao

Overview:
Instruction fetch/issue stage that sits directly upstream of the processor control unit (controle). It reads 9-bit instruction words (III XXX YYY) from a synchronous instruction memory and presents each one on ir. For MVI it fetches the immediate word and presents it on din. It then pulses run and waits for done before advancing the program counter.

Parameters:
ADDR_W, 5, instruction memory address width; PC wraps modulo 2^ADDR_W
WORD_W, 9, instruction/data word width (fixed III XXX YYY format)
MEM_LATENCY, 1, cycles from mem_rd to valid mem_data (1..3)
START_ADDR, 0, PC value after reset and after restart from HALTED
MVI_OP, 3'b001, opcode that carries an immediate in the following word
HLT_OP, 3'b111, opcode that stops fetching

Ports:
clock  input  1  single system clock, rising edge
resetn  input  1  asynchronous reset, active-high (asserted = 1)
start  input  1  begin fetching; honoured in IDLE and HALTED only
mem_addr  output  ADDR_W  instruction memory address
mem_rd  output  1  read strobe, one cycle per word
mem_data  input  WORD_W  memory read data, valid MEM_LATENCY cycles after mem_rd
ir  output  WORD_W  instruction to controle, stable from ISSUE until done accepted
din  output  WORD_W  MVI immediate to datapath, stable with ir
run  output  1  one-cycle issue pulse to controle
done  input  1  instruction complete, from controle
pc  output  ADDR_W  address of current instruction
halted  output  1  high while in HALTED

Behaviour:
- Reset (async, any state, mid-operation included): state=IDLE, pc=START_ADDR, mem_addr=START_ADDR, mem_rd=0, ir=0, din=0, run=0, halted=0. Pending memory reads are discarded.
- States: IDLE, FETCH, WAIT, IMM_FETCH, IMM_WAIT, ISSUE, WAIT_DONE, HALTED.
- IDLE: start=1 -> FETCH.
- FETCH (1 cycle): mem_addr=pc, mem_rd=1 -> WAIT.
- WAIT: lasts exactly MEM_LATENCY cycles, tracked by a latency counter. mem_data is sampled on the edge ending the last WAIT cycle:
  - opcode==HLT_OP -> HALTED, ir not loaded.
  - opcode==MVI_OP -> ir loaded, go to IMM_FETCH.
  - otherwise -> ir loaded, din unchanged, go to ISSUE.
- IMM_FETCH (1 cycle): mem_addr=pc+1 (mod 2^ADDR_W), mem_rd=1 -> IMM_WAIT.
- IMM_WAIT: lasts MEM_LATENCY cycles; din loaded on the last edge -> ISSUE.
- ISSUE (1 cycle): run=1 -> WAIT_DONE. done is ignored during ISSUE.
- WAIT_DONE: run=0. On done=1: pc += 2 for MVI, else pc += 1, modulo 2^ADDR_W -> FETCH.
- Latency, MEM_LATENCY=1: non-MVI, start sampled to run high takes 3 cycles; MVI takes 5 cycles. done accepted to next mem_rd takes 1 cycle.
- HALTED: halted=1, mem_rd=0, run=0; pc holds the HLT address. start=1 -> pc=START_ADDR, halted=0 -> FETCH.
- Boundaries:
  - MVI at the last address takes its immediate from address 0 (wrap).
  - pc increment wraps silently.
  - start outside IDLE/HALTED is ignored.
  - done outside WAIT_DONE is ignored.
  - done held high across cycles completes only one instruction per WAIT_DONE visit.
- mem_rd is never asserted in two consecutive cycles. mem_addr holds its last value when mem_rd=0.

Decomposition:
- Shared package (processador_pkg):
  - opcode constants MV=000, MVI=001, ADD=010, SUB=011, HLT=111
  - WORD_W
  - state enumeration for busca_instrucao
  - field-extract functions opcode(ir), rx(ir), ry(ir)
- One natural sub-module: contador_programa. It is the PC register with load-START, +1/+2 increment and modulo wrap; busca_instrucao holds the FSM and latency counter.

Test Plan:
- Memory {0:001000000 MVI R0, 1:000000101 (5), 2:000001000 MV R1,R0, 3:111000000}; start; done 2 cycles after each run -> run pulses with ir=001000000 & din=5, then ir=000001000; halted=1 with pc=3; exactly 2 run pulses.
- ADD/SUB sequence 010001001, 011010000 at addrs 0-1, MEM_LATENCY=2 -> each run occurs exactly 4 cycles after the preceding done (or start); ir matches memory; pc steps 0,1,2.
- MVI at addr 31 (ADDR_W=5), immediate at addr 0 = 9'h0AA -> second mem_rd with mem_addr=0, din=0AA; after done pc=1.
- resetn pulsed during WAIT_DONE and again during IMM_WAIT -> all outputs at reset values immediately; no run until new start; refetch from addr 0.
- done held high continuously and start toggled every cycle -> one instruction per run pulse; no extra fetch; start has no effect outside IDLE/HALTED.
- In HALTED, assert start -> pc=0, halted drops, mem_rd at addr 0 on the next cycle.

Source files
------------

// File: rtl/processador_pkg.sv
// Shared definitions for the processor front end: word format, opcodes,
// fetch-stage state encoding and instruction field extraction.
package processador_pkg;

  localparam int unsigned WORD_W = 9;
  localparam int unsigned OP_W   = 3;

  localparam logic [OP_W-1:0] OP_MV  = 3'b000;
  localparam logic [OP_W-1:0] OP_MVI = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b011;
  localparam logic [OP_W-1:0] OP_HLT = 3'b111;

  typedef enum logic [2:0] {
    st_idle,
    st_fetch,
    st_wait,
    st_imm_fetch,
    st_imm_wait,
    st_issue,
    st_wait_done,
    st_halted
  } busca_state_t;

  // Instruction word layout: III XXX YYY
  function automatic logic [OP_W-1:0] opcode(input logic [WORD_W-1:0] w);
    return w[8:6];
  endfunction

  function automatic logic [2:0] rx(input logic [WORD_W-1:0] w);
    return w[5:3];
  endfunction

  function automatic logic [2:0] ry(input logic [WORD_W-1:0] w);
    return w[2:0];
  endfunction

endpackage

// File: rtl/contador_programa.sv
// Program counter: reset/load to START_ADDR, +1 or +2 increment, silent
// modulo-2^ADDR_W wrap.
// Ports: clock, rst (async, active-high), load_start, inc, inc_two,
//        pc (registered), pc_nxt_c (value pc takes on the next edge).
module contador_programa #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              load_start,
  input  logic              inc,
  input  logic              inc_two,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_nxt_c
);

  // Next PC; exposed so the fetch address can be registered alongside pc
  always_comb begin
    pc_nxt_c = pc;
    if (load_start) begin
      pc_nxt_c = ADDR_W'(START_ADDR);
    end else if (inc) begin
      pc_nxt_c = inc_two ? pc + ADDR_W'(2) : pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pc <= ADDR_W'(START_ADDR);
    end else begin
      pc <= pc_nxt_c;
    end
  end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch/issue stage feeding controle. Reads the instruction word
// (and the MVI immediate from the following address), presents them on ir/din,
// pulses run and waits for done before advancing the PC.
// Ports: clock, resetn (async, active-high), start; memory side mem_addr,
//        mem_rd, mem_data; controle side ir, din, run, done; status pc, halted.
module busca_instrucao
  import processador_pkg::*;
#(
  parameter int unsigned     ADDR_W      = 5,
  parameter int unsigned     WORD_W      = processador_pkg::WORD_W,
  parameter int unsigned     MEM_LATENCY = 1,
  parameter int unsigned     START_ADDR  = 0,
  parameter logic [OP_W-1:0] MVI_OP      = OP_MVI,
  parameter logic [OP_W-1:0] HLT_OP      = OP_HLT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [WORD_W-1:0] mem_data,
  output logic [WORD_W-1:0] ir,
  output logic [WORD_W-1:0] din,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam int unsigned LAT_W = 2;

  busca_state_t      state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              lat_last_c;
  logic [OP_W-1:0]   mem_op_c;
  logic              pc_load, pc_inc, pc_inc_two;
  logic [ADDR_W-1:0] pc_nxt_c;

  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_rd_d, run_d, halted_d;
  logic [WORD_W-1:0] ir_d, din_d;

  assign mem_op_c   = mem_data[WORD_W-1 -: OP_W];
  assign lat_last_c = (lat_q == LAT_W'(MEM_LATENCY - 1));
  // ir holds the current instruction until done, so it tells us the step size
  assign pc_inc_two = (ir[WORD_W-1 -: OP_W] == MVI_OP);

  contador_programa #(
    .ADDR_W    (ADDR_W),
    .START_ADDR(START_ADDR)
  ) u_pc (
    .clock     (clock),
    .rst       (resetn),
    .load_start(pc_load),
    .inc       (pc_inc),
    .inc_two   (pc_inc_two),
    .pc        (pc),
    .pc_nxt_c  (pc_nxt_c)
  );

  // State and memory-latency counter
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      state_q <= st_idle;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // Next state, PC control and instruction/immediate capture
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    ir_d    = ir;
    din_d   = din;
    case (state_q)
      st_idle: begin
        if (start) begin
          pc_load = 1'b1;
          state_d = st_fetch;
        end
      end
      st_fetch: begin
        lat_d   = '0;
        state_d = st_wait;
      end
      st_wait: begin
        if (lat_last_c) begin
          if (mem_op_c == HLT_OP) begin
            state_d = st_halted;
          end else begin
            ir_d    = mem_data;
            state_d = (mem_op_c == MVI_OP) ? st_imm_fetch : st_issue;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      st_imm_fetch: begin
        lat_d   = '0;
        state_d = st_imm_wait;
      end
      st_imm_wait: begin
        if (lat_last_c) begin
          din_d   = mem_data;
          state_d = st_issue;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      st_issue: begin
        state_d = st_wait_done;
      end
      st_wait_done: begin
        if (done) begin
          pc_inc  = 1'b1;
          state_d = st_fetch;
        end
      end
      st_halted: begin
        if (start) begin
          pc_load = 1'b1;
          state_d = st_fetch;
        end
      end
      default: state_d = st_idle;
    endcase
  end

  // Output values for the state being entered, so outputs line up with it
  always_comb begin
    mem_addr_d = mem_addr;
    mem_rd_d   = 1'b0;
    if (state_d == st_fetch) begin
      mem_rd_d   = 1'b1;
      mem_addr_d = pc_nxt_c;
    end else if (state_d == st_imm_fetch) begin
      mem_rd_d   = 1'b1;
      mem_addr_d = pc + ADDR_W'(1);
    end
    run_d    = (state_d == st_issue);
    halted_d = (state_d == st_halted);
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      mem_addr <= ADDR_W'(START_ADDR);
      mem_rd   <= 1'b0;
      ir       <= '0;
      din      <= '0;
      run      <= 1'b0;
      halted   <= 1'b0;
    end else begin
      mem_addr <= mem_addr_d;
      mem_rd   <= mem_rd_d;
      ir       <= ir_d;
      din      <= din_d;
      run      <= run_d;
      halted   <= halted_d;
    end
  end

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: one instance with 1-cycle memory, one with
// 2-cycle memory; issued instructions are checked against a scoreboard.
module tb_busca_instrucao;
  import processador_pkg::*;

  localparam logic [8:0] HLT_W = 9'b111000000;

  typedef struct packed {
    logic [8:0] ir;
    logic [8:0] din;
    logic [4:0] pc;
  } exp_t;

  typedef struct {
    logic [8:0] w0;
    logic [8:0] w1;
    logic       is_mvi;
    logic       exp_run;
    int         exp_lat;
    logic [8:0] exp_din;
    logic [4:0] exp_halt_pc;
  } vec_t;

  logic       clock;
  logic       resetn;
  logic       start, done;
  logic [4:0] mem_addr, pc;
  logic       mem_rd, run, halted;
  logic [8:0] mem_data, ir, din;

  logic       start2, done2;
  logic [4:0] mem_addr2, pc2;
  logic       mem_rd2, run2, halted2;
  logic [8:0] mem_data2, ir2, din2;

  logic [8:0] mem1[32];
  logic [8:0] mem2[32];
  logic [8:0] q2a;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   run_cnt  = 0;
  int   rd_cnt   = 0;
  logic prev_rd  = 1'b0;
  logic [4:0] last_rd_addr = '0;
  logic [4:0] prev_rd_addr = '0;
  exp_t sb[$];
  exp_t e_mon;

  busca_instrucao #(.MEM_LATENCY(1)) dut (
    .clock(clock), .resetn(resetn), .start(start),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .ir(ir), .din(din), .run(run), .done(done), .pc(pc), .halted(halted)
  );

  busca_instrucao #(.MEM_LATENCY(2)) dut2 (
    .clock(clock), .resetn(resetn), .start(start2),
    .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_data(mem_data2),
    .ir(ir2), .din(din2), .run(run2), .done(done2), .pc(pc2), .halted(halted2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous memories; data only appears when a read was strobed
  always @(posedge clock) begin
    mem_data  <= mem_rd ? mem1[mem_addr] : 9'h000;
    q2a       <= mem_rd2 ? mem2[mem_addr2] : 9'h000;
    mem_data2 <= q2a;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and read-strobe monitor for the main instance
  always @(negedge clock) begin
    if (!resetn && run) begin
      run_cnt++;
      check("run_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e_mon = sb.pop_front();
        check("run_ir", 32'(ir), 32'(e_mon.ir));
        check("run_din", 32'(din), 32'(e_mon.din));
        check("run_pc", 32'(pc), 32'(e_mon.pc));
      end
    end
    if (!resetn && mem_rd) begin
      check("rd_not_back_to_back", 32'(prev_rd), 0);
      rd_cnt++;
      prev_rd_addr = last_rd_addr;
      last_rd_addr = mem_addr;
    end
    prev_rd = mem_rd;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, 32'(pc), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_rd"}, 32'(mem_rd), 0);
    check({tag, "_ir"}, 32'(ir), 0);
    check({tag, "_din"}, 32'(din), 0);
    check({tag, "_run"}, 32'(run), 0);
    check({tag, "_halted"}, 32'(halted), 0);
  endtask

  task automatic apply_reset();
    resetn = 1'b1;
    start  = 1'b0;
    done   = 1'b0;
    start2 = 1'b0;
    done2  = 1'b0;
    sb.delete();
    repeat (2) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
  endtask

  task automatic fill_hlt();
    for (int i = 0; i < 32; i++) mem1[i] = HLT_W;
  endtask

  task automatic start_and_wait(input int budget, output int cycles);
    start  = 1'b1;
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
      start = 1'b0;
    end while (!run && cycles < budget);
    check("run_within_budget", 32'(run), 1);
  endtask

  task automatic wait_run(input int budget);
    int c;
    c = 0;
    do begin
      @(negedge clock);
      c++;
    end while (!run && c < budget);
    check("run_within_budget", 32'(run), 1);
  endtask

  task automatic give_done(input int wait_cyc, input logic [4:0] nxt_pc);
    repeat (wait_cyc) @(negedge clock);
    done = 1'b1;
    @(negedge clock);
    done = 1'b0;
    check("done_to_rd", 32'(mem_rd), 1);
    check("next_addr", 32'(mem_addr), 32'(nxt_pc));
    check("next_pc", 32'(pc), 32'(nxt_pc));
  endtask

  task automatic wait_halt(input int budget);
    int c;
    c = 0;
    while (!halted && c < budget) begin
      @(negedge clock);
      c++;
    end
    check("halt_within_budget", 32'(halted), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   lat;
    int   r0, rd0, c;
    logic [8:0] prog_a[4];

    vecs[0] = '{9'b000001000, 9'h000, 1'b0, 1'b1, 3, 9'h000, 5'd1};
    vecs[1] = '{9'b001010000, 9'h155, 1'b1, 1'b1, 5, 9'h155, 5'd2};
    vecs[2] = '{9'b010001001, 9'h000, 1'b0, 1'b1, 3, 9'h000, 5'd1};
    vecs[3] = '{9'b011010000, 9'h000, 1'b0, 1'b1, 3, 9'h000, 5'd1};
    vecs[4] = '{9'b100111111, 9'h000, 1'b0, 1'b1, 3, 9'h000, 5'd1};
    vecs[5] = '{HLT_W,        9'h000, 1'b0, 1'b0, 0, 9'h000, 5'd0};
    prog_a  = '{9'b001000000, 9'b000000101, 9'b000001000, HLT_W};

    for (int i = 0; i < 32; i++) begin
      mem1[i] = HLT_W;
      mem2[i] = HLT_W;
    end
    apply_reset();
    check_reset_outputs("reset");

    // Single-instruction programs from the vector table
    for (int v = 0; v < 6; v++) begin
      apply_reset();
      fill_hlt();
      mem1[0] = vecs[v].w0;
      if (vecs[v].is_mvi) mem1[1] = vecs[v].w1;
      r0 = run_cnt;
      if (vecs[v].exp_run) begin
        sb.push_back('{ir: vecs[v].w0, din: vecs[v].exp_din, pc: 5'd0});
        start_and_wait(20, lat);
        check("start_to_run", 32'(lat), 32'(vecs[v].exp_lat));
        give_done(1, vecs[v].exp_halt_pc);
      end else begin
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
      wait_halt(20);
      check("halt_pc", 32'(pc), 32'(vecs[v].exp_halt_pc));
      check("halt_mem_rd", 32'(mem_rd), 0);
      check("runs_per_vector", 32'(run_cnt - r0), 32'(vecs[v].exp_run));
      check("sb_drained", 32'(sb.size()), 0);
      if (!vecs[v].exp_run) check("hlt_not_loaded", 32'(ir), 0);
    end

    // MVI / MV / HLT program with done two cycles after each run
    apply_reset();
    fill_hlt();
    for (int i = 0; i < 4; i++) mem1[i] = prog_a[i];
    r0 = run_cnt;
    sb.push_back('{ir: 9'b001000000, din: 9'h005, pc: 5'd0});
    sb.push_back('{ir: 9'b000001000, din: 9'h005, pc: 5'd2});
    start_and_wait(20, lat);
    check("mvi_start_to_run", 32'(lat), 5);
    give_done(2, 5'd2);
    wait_run(20);
    give_done(2, 5'd3);
    wait_halt(20);
    check("prog_halt_pc", 32'(pc), 3);
    check("prog_run_count", 32'(run_cnt - r0), 2);

    // Restart from HALTED
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("restart_pc", 32'(pc), 0);
    check("restart_halted", 32'(halted), 0);
    check("restart_mem_rd", 32'(mem_rd), 1);
    check("restart_mem_addr", 32'(mem_addr), 0);

    // MVI at the last address takes its immediate from address 0
    apply_reset();
    mem1[0] = 9'h0AA;
    for (int i = 1; i < 31; i++) mem1[i] = {3'b000, 6'(i)};
    mem1[31] = 9'b001000000;
    for (int i = 0; i < 31; i++) sb.push_back('{ir: mem1[i], din: 9'h000, pc: 5'(i)});
    sb.push_back('{ir: 9'b001000000, din: 9'h0AA, pc: 5'd31});
    start_and_wait(20, lat);
    give_done(1, 5'd1);
    for (int i = 1; i < 32; i++) begin
      wait_run(20);
      if (i == 31) begin
        check("wrap_fetch_addr", 32'(prev_rd_addr), 31);
        check("wrap_imm_addr", 32'(last_rd_addr), 0);
      end
      give_done(1, (i == 31) ? 5'd1 : 5'(i + 1));
    end

    // Asynchronous reset in WAIT_DONE
    apply_reset();
    fill_hlt();
    for (int i = 0; i < 4; i++) mem1[i] = prog_a[i];
    sb.push_back('{ir: 9'b001000000, din: 9'h005, pc: 5'd0});
    start_and_wait(20, lat);
    @(negedge clock);
    #2 resetn = 1'b1;
    #1 check_reset_outputs("rst_wait_done");
    sb.delete();
    @(negedge clock);
    resetn = 1'b0;
    r0 = run_cnt;
    repeat (8) @(negedge clock);
    check("no_run_after_reset", 32'(run_cnt - r0), 0);

    // Asynchronous reset in IMM_WAIT, then a clean refetch from 0
    sb.push_back('{ir: 9'b001000000, din: 9'h005, pc: 5'd0});
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    check("imm_wait_ir_loaded", 32'(ir), 32'(9'b001000000));
    #2 resetn = 1'b1;
    #1 check_reset_outputs("rst_imm_wait");
    sb.delete();
    @(negedge clock);
    resetn = 1'b0;
    sb.push_back('{ir: 9'b001000000, din: 9'h005, pc: 5'd0});
    start_and_wait(20, lat);
    check("refetch_lat", 32'(lat), 5);
    check("refetch_addr", 32'(prev_rd_addr), 0);
    check("refetch_imm_addr", 32'(last_rd_addr), 1);

    // done held high while start toggles every cycle
    apply_reset();
    fill_hlt();
    mem1[0] = 9'b010001001;
    mem1[1] = 9'b011010000;
    mem1[2] = 9'b000001000;
    sb.push_back('{ir: 9'b010001001, din: 9'h000, pc: 5'd0});
    sb.push_back('{ir: 9'b011010000, din: 9'h000, pc: 5'd1});
    sb.push_back('{ir: 9'b000001000, din: 9'h000, pc: 5'd2});
    r0   = run_cnt;
    rd0  = rd_cnt;
    done = 1'b1;
    c    = 0;
    while (!halted && c < 100) begin
      start = !start;
      @(negedge clock);
      c++;
    end
    start = 1'b0;
    done  = 1'b0;
    check("toggle_halted", 32'(halted), 1);
    check("toggle_halt_pc", 32'(pc), 3);
    check("toggle_run_count", 32'(run_cnt - r0), 3);
    check("toggle_rd_count", 32'(rd_cnt - rd0), 4);
    check("toggle_sb_drained", 32'(sb.size()), 0);

    // Two-cycle memory: run four cycles after start and after each done
    apply_reset();
    mem2[0] = 9'b010001001;
    mem2[1] = 9'b011010000;
    mem2[2] = HLT_W;
    start2 = 1'b1;
    c = 0;
    do begin
      @(negedge clock);
      c++;
      start2 = 1'b0;
    end while (!run2 && c < 20);
    check("ml2_start_to_run", 32'(c), 4);
    check("ml2_ir0", 32'(ir2), 32'(9'b010001001));
    check("ml2_pc0", 32'(pc2), 0);
    @(negedge clock);
    done2 = 1'b1;
    c = 0;
    do begin
      @(negedge clock);
      c++;
      done2 = 1'b0;
    end while (!run2 && c < 20);
    check("ml2_done_to_run", 32'(c), 4);
    check("ml2_ir1", 32'(ir2), 32'(9'b011010000));
    check("ml2_pc1", 32'(pc2), 1);
    @(negedge clock);
    done2 = 1'b1;
    @(negedge clock);
    done2 = 1'b0;
    c = 0;
    while (!halted2 && c < 20) begin
      @(negedge clock);
      c++;
    end
    check("ml2_halted", 32'(halted2), 1);
    check("ml2_halt_pc", 32'(pc2), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
